mem_stage: RTL and testbench

Fourth stage of the 5-stage pipeline: consumes the EX-stage products (`mem_ir`, `reg_C`, `smdr1`, `dw`) and performs the data-memory access. A small direct-mapped, write-through, no-write-allocate data cache sits in front of an external word-addressed memory reached by a req/ack handshake. The stage stalls upstream stages on misses and stores, then hands the instruction and its result to WB.

---
 rtl/mem_stage.sv | 186 ++++++++++++++++++
 tb/tb_mem_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: data-memory access stage of the 5-stage pipeline.
// A direct-mapped, write-through, no-write-allocate cache with one-word
// lines sits in front of an external word-addressed memory reached by a
// req/ack handshake. Misses and stores stall the upstream stages.
// Optional feature macro: MEM_CACHE_EN. When it is undefined there is no
// cache storage, and every LOAD goes to external memory.
module mem_stage #(
    parameter int IDX_W = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] mem_ir,
    input  logic [15:0] reg_C,
    input  logic [15:0] smdr1,
    input  logic        dw,
    output logic [15:0] wb_ir,
    output logic [15:0] reg_C1,
    output logic        stall,
    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_rd,
    output logic        m_wr,
    input  logic [15:0] m_rdata,
    input  logic        m_ack
);

    localparam logic [4:0] OP_LOAD = 5'b00010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2
    } fsm_e;

    fsm_e        fsm_q, fsm_d;
    logic [15:0] wb_ir_q, wb_ir_d;
    logic [15:0] reg_c1_q, reg_c1_d;
    logic [15:0] m_addr_q, m_addr_d;
    logic [15:0] m_wdata_q, m_wdata_d;

    logic        is_load;
    logic        lkp_hit;
    logic [15:0] lkp_data;

    assign is_load = (mem_ir[15:11] == OP_LOAD);

    // Next-state, datapath next values and the combinational stall.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave a latch behind.
        fsm_d     = fsm_q;
        wb_ir_d   = wb_ir_q;
        reg_c1_d  = reg_c1_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        stall     = 1'b0;

        case (fsm_q)
            S_IDLE: begin
                if (state) begin
                    if (dw) begin
                        // Write-through: every store goes to memory.
                        m_addr_d  = reg_C;
                        m_wdata_d = smdr1;
                        wb_ir_d   = 16'h0000;
                        fsm_d     = S_WR;
                        stall     = 1'b1;
                    end else if (is_load && !lkp_hit) begin
                        m_addr_d = reg_C;
                        wb_ir_d  = 16'h0000;
                        fsm_d    = S_RD;
                        stall    = 1'b1;
                    end else if (is_load) begin
                        reg_c1_d = lkp_data;
                        wb_ir_d  = mem_ir;
                    end else begin
                        reg_c1_d = reg_C;
                        wb_ir_d  = mem_ir;
                    end
                end
            end
            S_RD: begin
                if (m_ack) begin
                    reg_c1_d = m_rdata;
                    wb_ir_d  = mem_ir;
                    fsm_d    = S_IDLE;
                end else begin
                    wb_ir_d = 16'h0000;
                    stall   = 1'b1;
                end
            end
            S_WR: begin
                if (m_ack) begin
                    reg_c1_d = reg_C;
                    wb_ir_d  = mem_ir;
                    fsm_d    = S_IDLE;
                end else begin
                    wb_ir_d = 16'h0000;
                    stall   = 1'b1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    // FSM state and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is assigned with <= so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            fsm_q     <= S_IDLE;
            wb_ir_q   <= 16'h0000;
            reg_c1_q  <= 16'h0000;
            m_addr_q  <= 16'h0000;
            m_wdata_q <= 16'h0000;
        end else begin
            fsm_q     <= fsm_d;
            wb_ir_q   <= wb_ir_d;
            reg_c1_q  <= reg_c1_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

`ifdef MEM_CACHE_EN
    localparam int TAG_W     = 16 - IDX_W;
    localparam int NUM_LINES = 1 << IDX_W;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [15:0]          data_q [NUM_LINES];

    logic [IDX_W-1:0] lkp_idx, acc_idx;
    logic [TAG_W-1:0] lkp_tag, acc_tag;
    logic             acc_hit;
    logic             fill_en;
    logic             upd_en;

    // Lookup uses the presented address; fill/update use the latched
    // request address, which stays stable for the whole access.
    assign lkp_idx  = reg_C[IDX_W-1:0];
    assign lkp_tag  = reg_C[15:IDX_W];
    assign acc_idx  = m_addr_q[IDX_W-1:0];
    assign acc_tag  = m_addr_q[15:IDX_W];
    assign lkp_hit  = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);
    assign lkp_data = data_q[lkp_idx];
    assign acc_hit  = valid_q[acc_idx] && (tag_q[acc_idx] == acc_tag);
    assign fill_en  = (fsm_q == S_RD) && m_ack;
    assign upd_en   = (fsm_q == S_WR) && m_ack && acc_hit;

    // Line valid bits: cleared on reset, set by a read fill.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
        end else if (fill_en) begin
            valid_q[acc_idx] <= 1'b1;
        end
    end

    // Tag and data arrays: fill on read ack, refresh data on a store hit.
    always_ff @(posedge clock) begin
        // NOTE: the arrays carry no reset; cleared valid bits make their
        // power-up contents unobservable and keep them plain RAM.
        if (!reset) begin
            if (fill_en) begin
                tag_q[acc_idx]  <= acc_tag;
                data_q[acc_idx] <= m_rdata;
            end else if (upd_en) begin
                data_q[acc_idx] <= m_wdata_q;
            end
        end
    end
`else
    assign lkp_hit  = 1'b0;
    assign lkp_data = 16'h0000;
`endif

    assign wb_ir   = wb_ir_q;
    assign reg_C1  = reg_c1_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_rd    = (fsm_q == S_RD);
    assign m_wr    = (fsm_q == S_WR);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage. The reference model
// tracks which address each cache index currently holds and the contents
// of external memory; load data always comes from that memory model,
// since a write-through cache never diverges from memory.
module tb_mem_stage;

    localparam int IDX_W = 3;
`ifdef MEM_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [15:0] IR_LOAD  = 16'h1000;
    localparam logic [15:0] IR_STORE = 16'h1800;
    localparam logic [15:0] IR_ADD   = 16'h0805;

    logic        clock = 1'b0;
    logic        reset;
    logic        state;
    logic [15:0] mem_ir;
    logic [15:0] reg_C;
    logic [15:0] smdr1;
    logic        dw;
    logic [15:0] wb_ir;
    logic [15:0] reg_C1;
    logic        stall;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic        m_rd;
    logic        m_wr;
    logic [15:0] m_rdata;
    logic        m_ack;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_model [logic [15:0]];
    logic [15:0] line_addr [int];

    mem_stage #(.IDX_W(IDX_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .state   (state),
        .mem_ir  (mem_ir),
        .reg_C   (reg_C),
        .smdr1   (smdr1),
        .dw      (dw),
        .wb_ir   (wb_ir),
        .reg_C1  (reg_C1),
        .stall   (stall),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rd    (m_rd),
        .m_wr    (m_wr),
        .m_rdata (m_rdata),
        .m_ack   (m_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem_model.exists(a) ? mem_model[a] : (a ^ 16'h5A3C);
    endfunction

    // Present one instruction at a negedge, act as external memory acking
    // on the (n+1)-th request cycle, and check the result against the model.
    task automatic run_op(input string tag, input logic [15:0] ir, input logic [15:0] c,
                          input logic [15:0] sd, input int n);
        logic        is_load, is_store, hit, go_mem, done, saw_rd, saw_wr, addr_ok, data_ok;
        logic [15:0] exp_c1, bubble;
        int          idx, stalls, req;
        is_load  = (ir[15:11] == 5'b00010);
        is_store = (ir[15:11] == 5'b00011);
        idx      = int'(c) % (1 << IDX_W);
        hit      = CACHE_EN && line_addr.exists(idx) && (line_addr[idx] == c);
        go_mem   = is_store || (is_load && !hit);
        exp_c1   = is_load ? mem_rd(c) : c;

        mem_ir = ir; reg_C = c; smdr1 = sd; dw = is_store; state = 1'b1; m_ack = 1'b0;
        stalls = 0; req = 0; done = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
        addr_ok = 1'b1; data_ok = 1'b1; bubble = 16'h0000;

        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (cyc == 1) bubble = wb_ir;
            if (m_rd || m_wr) begin
                saw_rd |= m_rd;
                saw_wr |= m_wr;
                req++;
                if (m_addr !== c) addr_ok = 1'b0;
                if (m_wr && m_wdata !== sd) data_ok = 1'b0;
                if (req == n + 1) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_rd(c);
                    if (m_wr) mem_model[c] = sd;
                end
            end
            #1;
            if (stall) stalls++;
            else done = 1'b1;
            @(negedge clock);
            m_ack = 1'b0;
        end

        check($sformatf("%s.done", tag), 16'(done), 16'd1);
        check($sformatf("%s.stall_cycles", tag), 16'(stalls), go_mem ? 16'(n + 1) : 16'd0);
        check($sformatf("%s.wb_ir", tag), wb_ir, ir);
        check($sformatf("%s.reg_C1", tag), reg_C1, exp_c1);
        check($sformatf("%s.saw_rd", tag), 16'(saw_rd), 16'(is_load && go_mem));
        check($sformatf("%s.saw_wr", tag), 16'(saw_wr), 16'(is_store));
        check($sformatf("%s.req_idle", tag), 16'(m_rd | m_wr), 16'd0);
        if (go_mem) begin
            check($sformatf("%s.m_addr_stable", tag), 16'(addr_ok), 16'd1);
            check($sformatf("%s.m_wdata_stable", tag), 16'(data_ok), 16'd1);
            check($sformatf("%s.bubble", tag), bubble, 16'h0000);
        end
        if (is_load && go_mem && CACHE_EN) line_addr[idx] = c;
    endtask

    initial begin
        logic [15:0] hold_ir, hold_c1;
        int          kind;

        reset = 1'b1; state = 1'b0; mem_ir = 16'h0000; reg_C = 16'h0000;
        smdr1 = 16'h0000; dw = 1'b0; m_rdata = 16'h0000; m_ack = 1'b0;
        mem_model[16'h0012] = 16'hBEEF;

        // Reset for two cycles, then check every output is zero.
        @(negedge clock);
        @(negedge clock);
        check("rst.wb_ir", wb_ir, 16'h0000);
        check("rst.reg_C1", reg_C1, 16'h0000);
        check("rst.m_addr", m_addr, 16'h0000);
        check("rst.m_wdata", m_wdata, 16'h0000);
        check("rst.m_rd", 16'(m_rd), 16'd0);
        check("rst.m_wr", 16'(m_wr), 16'd0);
        check("rst.stall", 16'(stall), 16'd0);
        reset = 1'b0;
        @(negedge clock);

        // Cold miss with ack three cycles after the request, then a repeat.
        run_op("load_cold", IR_LOAD, 16'h0012, 16'h0000, 3);
        run_op("load_again", IR_LOAD | 16'h0001, 16'h0012, 16'h0000, 2);

        // Store through, then a load that sees the new value.
        run_op("store", IR_STORE, 16'h0012, 16'h1234, 2);
        run_op("load_after_store", IR_LOAD, 16'h0012, 16'h0000, 1);

        // Conflict on index 2.
        run_op("conf_a", IR_LOAD, 16'h0012, 16'h0000, 1);
        run_op("conf_b", IR_LOAD, 16'h001A, 16'h0000, 2);
        run_op("conf_a_again", IR_LOAD, 16'h0012, 16'h0000, 1);

        // Non-memory instruction passes straight through.
        run_op("add", IR_ADD, 16'h0042, 16'h0000, 1);

        // state = 0: outputs hold and nothing is requested, even for a load.
        hold_ir = IR_ADD; hold_c1 = 16'h0042;
        state = 1'b0; mem_ir = IR_LOAD; reg_C = 16'h0077; dw = 1'b0;
        #1;
        check("idle.stall", 16'(stall), 16'd0);
        @(negedge clock);
        @(negedge clock);
        check("idle.wb_ir", wb_ir, hold_ir);
        check("idle.reg_C1", reg_C1, hold_c1);
        check("idle.m_rd", 16'(m_rd), 16'd0);

        // Reset while a read is outstanding; a late ack must be ignored.
        state = 1'b1; mem_ir = IR_LOAD; reg_C = 16'h0022; dw = 1'b0;
        @(negedge clock);
        check("rst_rd.m_rd_before", 16'(m_rd), 16'd1);
        reset = 1'b1;
        @(negedge clock);
        line_addr.delete();
        check("rst_rd.m_rd_after", 16'(m_rd), 16'd0);
        check("rst_rd.wb_ir", wb_ir, 16'h0000);
        reset = 1'b0; state = 1'b0; mem_ir = 16'h0000; m_ack = 1'b1; m_rdata = 16'hDEAD;
        @(negedge clock);
        m_ack = 1'b0;
        check("late_ack.m_rd", 16'(m_rd), 16'd0);
        check("late_ack.m_wr", 16'(m_wr), 16'd0);
        check("late_ack.wb_ir", wb_ir, 16'h0000);
        check("late_ack.reg_C1", reg_C1, 16'h0000);
        run_op("load_after_rst", IR_LOAD, 16'h0012, 16'h0000, 2);
        run_op("load_after_rst2", IR_LOAD, 16'h0012, 16'h0000, 1);

        // Randomized mix over a small address range to provoke hits and conflicts.
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            case (kind)
                0: run_op($sformatf("rnd%0d.ld", i), IR_LOAD | 16'($urandom_range(0, 2047)),
                          16'($urandom_range(0, 31)), 16'h0000, int'($urandom_range(1, 4)));
                1: run_op($sformatf("rnd%0d.st", i), IR_STORE | 16'($urandom_range(0, 2047)),
                          16'($urandom_range(0, 31)), 16'($urandom), int'($urandom_range(1, 4)));
                default: run_op($sformatf("rnd%0d.op", i),
                                {5'($urandom_range(4, 31)), 11'($urandom_range(0, 2047))},
                                16'($urandom), 16'($urandom), 1);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
